// File: rtl/transmisor_uart_configurable.sv
// UART transmitter with configurable word length, parity mode and stop-bit count.
// Frame: start bit, LSB-first data, optional parity, one or two stop bits; all outputs registered.
module transmisor_uart_configurable #(
    parameter int unsigned CICLOS_POR_BIT = 10417,
    parameter int unsigned BITS_DATOS     = 8
) (
    input  logic                  reloj,
    input  logic                  reinicio,
    input  logic [BITS_DATOS-1:0] datosEntrada,
    input  logic                  datosValidos,
    output logic                  listo,
    input  logic [1:0]            modoParidad,
    input  logic                  dosBitsParada,
    output logic                  lineaTx,
    output logic                  ocupado,
    output logic                  tramaTerminada
);

    localparam int unsigned CNT_W = $clog2(CICLOS_POR_BIT);
    localparam int unsigned IDX_W = $clog2(BITS_DATOS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CICLOS_POR_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BITS_DATOS - 1);

    typedef enum logic [2:0] {
        ESPERA  = 3'd0,
        INICIO  = 3'd1,
        DATOS   = 3'd2,
        PARIDAD = 3'd3,
        PARADA  = 3'd4
    } estado_t;

    estado_t               estado_q, estado_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BITS_DATOS-1:0] desp_q, desp_d;
    logic                  par_q, par_d;
    logic                  con_par_q, con_par_d;
    logic                  dos_q, dos_d;
    logic                  segunda_q, segunda_d;
    logic                  linea_q, linea_d;
    logic                  listo_q, listo_d;
    logic                  ocup_q, ocup_d;
    logic                  fin_q, fin_d;
    logic                  fin_bit;

    assign fin_bit = (cnt_q == CNT_MAX);

    // State and registered outputs
    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            estado_q  <= ESPERA;
            cnt_q     <= '0;
            idx_q     <= '0;
            desp_q    <= '0;
            par_q     <= 1'b0;
            con_par_q <= 1'b0;
            dos_q     <= 1'b0;
            segunda_q <= 1'b0;
            linea_q   <= 1'b1;
            listo_q   <= 1'b0;
            ocup_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            desp_q    <= desp_d;
            par_q     <= par_d;
            con_par_q <= con_par_d;
            dos_q     <= dos_d;
            segunda_q <= segunda_d;
            linea_q   <= linea_d;
            listo_q   <= listo_d;
            ocup_q    <= ocup_d;
            fin_q     <= fin_d;
        end
    end

    // Next state; output values are those for the cycle after the edge
    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        desp_d    = desp_q;
        par_d     = par_q;
        con_par_d = con_par_q;
        dos_d     = dos_q;
        segunda_d = segunda_q;
        linea_d   = 1'b1;
        listo_d   = 1'b0;
        ocup_d    = 1'b1;

        case (estado_q)
            ESPERA: begin
                ocup_d  = 1'b0;
                listo_d = 1'b1;
                if (listo_q && datosValidos) begin
                    estado_d  = INICIO;
                    cnt_d     = '0;
                    idx_d     = '0;
                    desp_d    = datosEntrada;
                    par_d     = (^datosEntrada) ^ (modoParidad == 2'b10);
                    con_par_d = (modoParidad == 2'b01) || (modoParidad == 2'b10);
                    dos_d     = dosBitsParada;
                    segunda_d = 1'b0;
                    linea_d   = 1'b0;
                    listo_d   = 1'b0;
                    ocup_d    = 1'b1;
                end
            end
            INICIO: begin
                linea_d = 1'b0;
                if (fin_bit) begin
                    cnt_d    = '0;
                    estado_d = DATOS;
                    linea_d  = desp_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATOS: begin
                // desp_q[0] always holds the bit currently on the line
                linea_d = desp_q[0];
                if (fin_bit) begin
                    cnt_d = '0;
                    if (idx_q == IDX_MAX) begin
                        if (con_par_q) begin
                            estado_d = PARIDAD;
                            linea_d  = par_q;
                        end else begin
                            estado_d = PARADA;
                            linea_d  = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        desp_d  = desp_q >> 1;
                        linea_d = desp_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARIDAD: begin
                linea_d = par_q;
                if (fin_bit) begin
                    cnt_d    = '0;
                    estado_d = PARADA;
                    linea_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARADA: begin
                if (fin_bit) begin
                    cnt_d = '0;
                    if (dos_q && !segunda_q) begin
                        segunda_d = 1'b1;
                    end else begin
                        estado_d  = ESPERA;
                        segunda_d = 1'b0;
                        ocup_d    = 1'b0;
                        listo_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                estado_d  = ESPERA;
                cnt_d     = '0;
                idx_d     = '0;
                segunda_d = 1'b0;
                ocup_d    = 1'b0;
            end
        endcase
    end

    // Pulse lands on the last cycle of the final stop bit
    assign fin_d = (estado_d == PARADA) && (cnt_d == CNT_MAX) && (!dos_q || segunda_d);

    assign lineaTx        = linea_q;
    assign listo          = listo_q;
    assign ocupado        = ocup_q;
    assign tramaTerminada = fin_q;

endmodule

// File: tb/tb_transmisor_uart_configurable.sv
// Bench for transmisor_uart_configurable: 8-bit and 5-bit instances at 4 cycles/bit,
// checked every cycle against a frame-list model, plus literal frame timing checks.
module tb_transmisor_uart_configurable;

    localparam int C = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] dat0;
    logic [4:0] dat1;
    logic       val  [2];
    logic [1:0] md   [2];
    logic       ds   [2];
    logic       linea[2];
    logic       listo[2];
    logic       ocup [2];
    logic       fin  [2];

    transmisor_uart_configurable #(.CICLOS_POR_BIT(C), .BITS_DATOS(8)) dut8 (
        .reloj(clk), .reinicio(rst_n), .datosEntrada(dat0), .datosValidos(val[0]),
        .listo(listo[0]), .modoParidad(md[0]), .dosBitsParada(ds[0]),
        .lineaTx(linea[0]), .ocupado(ocup[0]), .tramaTerminada(fin[0])
    );

    transmisor_uart_configurable #(.CICLOS_POR_BIT(C), .BITS_DATOS(5)) dut5 (
        .reloj(clk), .reinicio(rst_n), .datosEntrada(dat1), .datosValidos(val[1]),
        .listo(listo[1]), .modoParidad(md[1]), .dosBitsParada(ds[1]),
        .lineaTx(linea[1]), .ocupado(ocup[1]), .tramaTerminada(fin[1])
    );

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 1'b0;
    int cap [0:127];
    int fin_cnt0 = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each accepted word becomes a list of line levels, one per cycle
    bit fr [2][64];
    int len [2] = '{0, 0};
    int pos [2] = '{0, 0};
    bit m_line [2] = '{1'b1, 1'b1};
    bit m_listo[2] = '{1'b0, 1'b0};
    bit m_ocup [2] = '{1'b0, 1'b0};
    bit m_fin  [2] = '{1'b0, 1'b0};

    task automatic build(input int k);
        int nb, d, ones, n;
        bit seq[$];
        nb = (k == 0) ? 8 : 5;
        d  = (k == 0) ? int'(dat0) : int'(dat1);
        ones = $countones(d);
        seq.push_back(1'b0);
        for (int i = 0; i < nb; i++) seq.push_back(((d >> i) & 1) != 0);
        if (md[k] == 2'b01) seq.push_back((ones % 2) == 1);
        else if (md[k] == 2'b10) seq.push_back((ones % 2) == 0);
        seq.push_back(1'b1);
        if (ds[k]) seq.push_back(1'b1);
        n = 0;
        foreach (seq[j]) for (int r = 0; r < C; r++) begin
            fr[k][n] = seq[j];
            n++;
        end
        len[k] = n;
        pos[k] = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                len[k] = 0; pos[k] = 0;
                m_line[k] = 1'b1; m_listo[k] = 1'b0; m_ocup[k] = 1'b0; m_fin[k] = 1'b0;
            end else if (pos[k] < len[k]) begin
                m_line[k] = fr[k][pos[k]];
                pos[k]++;
                m_listo[k] = 1'b0; m_ocup[k] = 1'b1; m_fin[k] = (pos[k] == len[k]);
            end else if (m_listo[k] && val[k]) begin
                build(k);
                m_line[k] = fr[k][0];
                pos[k] = 1;
                m_listo[k] = 1'b0; m_ocup[k] = 1'b1; m_fin[k] = 1'b0;
            end else begin
                m_line[k] = 1'b1; m_listo[k] = 1'b1; m_ocup[k] = 1'b0; m_fin[k] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (fin[0]) fin_cnt0++;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("lineaTx[%0d]", k), int'(linea[k]), int'(m_line[k]));
                chk($sformatf("listo[%0d]", k), int'(listo[k]), int'(m_listo[k]));
                chk($sformatf("ocupado[%0d]", k), int'(ocup[k]), int'(m_ocup[k]));
                chk($sformatf("tramaTerminada[%0d]", k), int'(fin[k]), int'(m_fin[k]));
            end
        end
    end

    function automatic int decode(input int nb);
        int v = 0;
        for (int i = 0; i < nb; i++) if (cap[C * (i + 1) + 2] != 0) v |= (1 << i);
        return v;
    endfunction

    // Offers a word when ready, captures the line per cycle after acceptance
    // (cap[1] is the first cycle), disturbs inputs mid-frame.
    task automatic send(input int k, input int data, input logic [1:0] m, input logic d,
                        input bit hold, output int fin_at);
        int g = 0;
        while (listo[k] !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk($sformatf("listo_before_send[%0d]", k), int'(listo[k]), 1);
        if (k == 0) dat0 = 8'(data); else dat1 = 5'(data);
        md[k] = m; ds[k] = d; val[k] = 1'b1;
        @(posedge clk);
        fin_at = -1;
        for (int c = 1; c <= 100 && fin_at < 0; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) val[k] = 1'b0;
            if (c == 10) begin
                if (k == 0) dat0 = ~dat0; else dat1 = ~dat1;
                md[k] = ~m; ds[k] = ~d;
                if (!hold) val[k] = 1'b1;
            end
            if (c == 11 && !hold) val[k] = 1'b0;
            cap[c] = int'(linea[k]);
            if (fin[k]) fin_at = c;
        end
        chk("start_bit_latency", cap[1], 0);
        @(negedge clk);
        chk("listo_after_frame", int'(listo[k]), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f, f0;
        dat0 = '0; dat1 = '0;
        val = '{1'b0, 1'b0}; md = '{2'b00, 2'b00}; ds = '{1'b0, 1'b0};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_linea", int'(linea[0]), 1);
        chk("reset_listo", int'(listo[0]), 0);
        chk("reset_ocupado", int'(ocup[0]), 0);
        chk("reset_fin", int'(fin[0]), 0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("listo_after_release", int'(listo[0]), 1);

        send(0, 8'h55, 2'b00, 1'b0, 1'b0, f);
        chk("8N1_fin_cycle", f, 40);
        chk("8N1_bit0", cap[5], 1);
        chk("8N1_bit1", cap[9], 0);
        chk("8N1_bit7", cap[36], 0);
        chk("8N1_stop", cap[37], 1);
        chk("8N1_decode", decode(8), 'h55);

        send(0, 8'h07, 2'b01, 1'b0, 1'b0, f);
        chk("even_fin_cycle", f, 44);
        chk("even_parity_bit", cap[38], 1);
        send(0, 8'h07, 2'b10, 1'b0, 1'b0, f);
        chk("odd_fin_cycle", f, 44);
        chk("odd_parity_bit", cap[38], 0);

        send(0, 8'hA3, 2'b00, 1'b1, 1'b0, f);
        chk("2stop_fin_cycle", f, 44);
        chk("2stop_bit4", cap[24], 0);
        chk("2stop_first", cap[37], 1);
        chk("2stop_last", cap[44], 1);
        chk("2stop_decode", decode(8), 'hA3);

        send(0, 8'h12, 2'b00, 1'b0, 1'b1, f);
        chk("b2b_first_fin", f, 40);
        chk("b2b_first_decode", decode(8), 'h12);
        send(0, 8'h34, 2'b00, 1'b0, 1'b0, f);
        chk("b2b_second_fin", f, 40);
        chk("b2b_second_decode", decode(8), 'h34);

        // Reset during data bit 3 of 0xFF (cycles 17..20 after acceptance)
        dat0 = 8'hFF; md[0] = 2'b00; ds[0] = 1'b0; val[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        val[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_reset_ocupado", int'(ocup[0]), 1);
        f0 = fin_cnt0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_linea", int'(linea[0]), 1);
        chk("async_reset_ocupado", int'(ocup[0]), 0);
        chk("async_reset_listo", int'(listo[0]), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("listo_after_midframe_reset", int'(listo[0]), 1);
        repeat (50) @(negedge clk);
        chk("no_fin_after_abort", fin_cnt0, f0);

        send(1, 5'h1F, 2'b10, 1'b0, 1'b0, f);
        chk("w5_fin_cycle", f, 32);
        chk("w5_data", cap[10], 1);
        chk("w5_odd_parity", cap[26], 0);
        chk("w5_decode", decode(5), 'h1F);

        repeat (3000) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                val[k] = ($urandom_range(0, 3) != 0);
                md[k]  = 2'($urandom);
                ds[k]  = 1'($urandom);
            end
            dat0 = 8'($urandom);
            dat1 = 5'($urandom);
            if ($urandom_range(0, 699) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
